// File: rtl/instr_mem_sync_pkg.sv
// Shared constants for the synchronous instruction store: fault bit positions,
// the default fault/NOP word and the legal read-latency range.
package instr_mem_sync_pkg;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 3;

  function automatic bit latency_legal(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/instr_mem_sync_ram.sv
// One-read/one-write synchronous RAM with a registered read port.
// A same-edge read and write to one word returns the old contents.
module ram_1r1w_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data
);

  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rd_data_q;

  // No reset: contents must survive a fetch-side reset, and this maps onto macros.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction RAM for the fetch stage: byte-address fetch with fault decode,
// LATENCY-stage read pipeline, flush squash and a boot-load write port.
module instr_mem_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] FAULT_WORD = NOP_WORD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_flush,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_instruction,
  output logic [1:0]            o_fault,
  input  logic                  i_load_en,
  input  logic [DEPTH_LOG2-1:0] i_load_addr,
  input  logic [31:0]           i_load_data,
  output logic                  o_busy
);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("instr_mem_sync: LATENCY must be in 1..3");
  end
  if (DEPTH_LOG2 > ADDR_WIDTH - 2) begin : g_bad_depth
    $error("instr_mem_sync: DEPTH_LOG2 must be <= ADDR_WIDTH-2");
  end

  logic                  accept;
  logic                  range_err;
  logic [1:0]            req_flt;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           ram_rdata;
  logic [31:0]           rsp_data;

  assign o_req_ready = !i_load_en && !i_flush;
  assign accept      = i_req_valid && o_req_ready;
  assign word_idx    = i_address[DEPTH_LOG2+1:2];

  if (DEPTH_LOG2 + 2 < ADDR_WIDTH) begin : g_range
    assign range_err = |i_address[ADDR_WIDTH-1:DEPTH_LOG2+2];
  end else begin : g_no_range
    assign range_err = 1'b0;
  end

  always_comb begin
    req_flt                 = '0;
    req_flt[FAULT_MISALIGN] = |i_address[1:0];
    req_flt[FAULT_RANGE]    = range_err;
  end

  // Faulting fetches never touch the array; the response is forced to FAULT_WORD.
  ram_1r1w_sync #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rd_en   (accept && (req_flt == 2'b00)),
    .i_rd_addr (word_idx),
    .o_rd_data (ram_rdata),
    .i_wr_en   (i_load_en),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data)
  );

  logic [LATENCY:1]      vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1][1:0] flt_pipe_q, flt_pipe_d;
  logic [31:0]           instr_q, instr_d;

  always_comb begin
    vld_pipe_d    = '0;
    flt_pipe_d    = '0;
    flt_pipe_d[1] = req_flt;
    for (int s = 2; s <= LATENCY; s++) flt_pipe_d[s] = flt_pipe_q[s-1];
    if (!i_flush) begin
      vld_pipe_d[1] = accept;
      for (int s = 2; s <= LATENCY; s++) vld_pipe_d[s] = vld_pipe_q[s-1];
    end
  end

  // Stage 1 data is the RAM's own output register; later stages are plain copies.
  if (LATENCY == 1) begin : g_lat1
    assign rsp_data = ram_rdata;
  end else begin : g_latn
    logic [LATENCY-1:1][31:0] dat_q, dat_d;

    always_comb begin
      dat_d    = dat_q;
      dat_d[1] = ram_rdata;
      for (int s = 2; s <= LATENCY - 1; s++) dat_d[s] = dat_q[s-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) dat_q <= '0;
      else          dat_q <= dat_d;
    end

    assign rsp_data = dat_q[LATENCY-1];
  end

  logic       rsp_valid;
  logic [1:0] rsp_flt;
  logic [31:0] rsp_word;

  // A response arriving in the flush cycle itself is squashed as well.
  assign rsp_valid = vld_pipe_q[LATENCY] && !i_flush;
  assign rsp_flt   = flt_pipe_q[LATENCY];
  assign rsp_word  = (rsp_flt != 2'b00) ? FAULT_WORD : rsp_data;

  assign o_rsp_valid   = rsp_valid;
  assign o_fault       = rsp_valid ? rsp_flt : 2'b00;
  assign o_instruction = rsp_valid ? rsp_word : instr_q;
  assign instr_d       = o_instruction;
  assign o_busy        = i_load_en || (|vld_pipe_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_q <= '0;
      flt_pipe_q <= '0;
      instr_q    <= FAULT_WORD;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      flt_pipe_q <= flt_pipe_d;
      instr_q    <= instr_d;
    end
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Synthesizable, parametrised successor to the simulation-only instruction store. It provides a word-addressed instruction RAM with a byte-address fetch port, a configurable read-pipeline latency, a valid/ready request handshake and a flush that squashes in-flight reads. It also has a boot-load write port so the program is written by the on-chip loader instead of a file. It sits between the fetch stage and the loader.

Parameters:
ADDR_WIDTH, 32, width of the byte fetch address.
DEPTH_LOG2, 10, log2 of the number of 32-bit words stored; must be ≤ ADDR_WIDTH-2.
LATENCY, 1, read latency in cycles, from accepted request to o_rsp_valid; legal values are 1..3.
FAULT_WORD, 32'h0000_0000, instruction returned on a fault (NOP).

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_req_valid  in  1  fetch request.
o_req_ready  out  1  request accepted when high together with i_req_valid.
i_address  in  ADDR_WIDTH  byte address of the fetch.
i_flush  in  1  squash all in-flight reads.
o_rsp_valid  out  1  response valid; the consumer always accepts it (no backpressure).
o_instruction  out  32  fetched word.
o_fault  out  2  bit0: misaligned address; bit1: out of range.
i_load_en  in  1  boot-load write strobe.
i_load_addr  in  DEPTH_LOG2  word index to write.
i_load_data  in  32  word to write.
o_busy  out  1  load active or reads in flight.

Behaviour:
- Reset (async assert, sync deassert): clear o_rsp_valid, o_fault, the pipeline valid bits and o_busy. o_instruction resets to FAULT_WORD. Memory contents are not reset.
- o_req_ready = !i_load_en && !i_flush.
- Accept: i_req_valid && o_req_ready. Word index = i_address[DEPTH_LOG2+1:2].
- Faults are decoded at accept time:
  - misaligned if i_address[1:0] != 0;
  - out of range if i_address[ADDR_WIDTH-1:DEPTH_LOG2+2] != 0.
  - Both bits can be set together.
  - On any fault the response carries FAULT_WORD and the RAM read is suppressed.
- Pipeline: a valid bit and fault bits travel through LATENCY stages. Stage 1 is the registered RAM read. Extra stages are plain registers.
- The response appears exactly LATENCY cycles after accept. Back-to-back accepts give one response per cycle; throughput is 1.
- o_instruction holds its last value when o_rsp_valid is low. o_fault is 0 when o_rsp_valid is low.
- Flush: in the i_flush cycle, all pipeline valid bits clear on the next edge. No response emerges for requests accepted before or during the flush cycle. A new accept is possible the cycle after.
- Load: on each edge with i_load_en high, mem[i_load_addr] <= i_load_data.
  - Requests are stalled while loading.
  - Reads already in flight complete normally.
  - A read and a write to the same word in the same cycle return the old data (read-before-write).
- o_busy = i_load_en || any pipeline valid bit.
- Reset mid-operation drops all in-flight responses immediately. Memory keeps its contents.

Decomposition:
- Shared package: FAULT_MISALIGN / FAULT_RANGE bit indices, the NOP encoding used as the default FAULT_WORD, and the LATENCY legal-range check constant.
- One natural sub-module: ram_1r1w_sync (DEPTH_LOG2, 32-bit, one registered read port, one write port, read-before-write), so it can be swapped for a vendor macro.

Test Plan:
- Reset, then load words 0..3 = 0x2000_0001..0x2000_0004, then fetch 0x0,0x4,0x8,0xC back-to-back with LATENCY=2 → o_rsp_valid on cycles 2..5 after the first accept, data in order, o_fault=0.
- Fetch 0x6 → FAULT_WORD with o_fault=2'b01. Fetch 1<<(DEPTH_LOG2+2) → FAULT_WORD with o_fault=2'b10. Fetch address 0xFFFF_FFFF → o_fault=2'b11.
- Three accepts, then i_flush in the following cycle, LATENCY=3 → no o_rsp_valid for those three. A fetch of 0x0 the cycle after the flush returns the word 3 cycles later.
- i_load_en high while i_req_valid high → o_req_ready=0 and no accept. A read in flight to word 5 while 0xDEAD_BEEF is written to word 5 → the old value is returned. A subsequent fetch of 0x14 → 0xDEAD_BEEF.
- Drop i_rst_n with two reads in flight → o_rsp_valid=0 immediately and never asserts for them. Loaded data survives (fetch of 0x0 after reset returns 0x2000_0001).
- Sweep LATENCY=1,2,3 over randomised back-to-back fetches → every response matches the model at exactly accept+LATENCY; o_busy tracks in-flight reads.
